// File: rtl/alu_req_scheduler.sv
// Two-requester round-robin scheduler that shares one external combinational ALU.
// Each operation goes through accept, one ALU settle cycle, then a held response.
module alu_req_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   input  logic [3:0]  req0_op,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   input  logic [3:0]  req1_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_op,
   input  logic [7:0]  alu_result,
   input  logic [15:0] alu_product,
   input  logic        alu_of,
   input  logic        alu_zero,
   input  logic        alu_slt,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [7:0]  rsp_result,
   output logic [15:0] rsp_product,
   output logic        rsp_of,
   output logic        rsp_zero,
   output logic        rsp_slt,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state, state_nxt;
   logic       last_grant;
   logic       grant_id;
   logic       op_id;
   logic       accept;
   logic       illegal;
   logic [7:0] sel_a, sel_b;
   logic [3:0] sel_op;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      grant_id  = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
      sel_a     = grant_id ? req1_a  : req0_a;
      sel_b     = grant_id ? req1_b  : req0_b;
      sel_op    = grant_id ? req1_op : req0_op;
      illegal   = (sel_op >= 4'b1100);
      accept    = 1'b0;
      req_ready = 2'b00;
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if ((|req_valid) && !rst) begin
               accept              = 1'b1;
               req_ready[grant_id] = 1'b1;
               state_nxt           = illegal ? RESP : EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between processes.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // The ALU operand registers load only for legal ops, so an illegal op never disturbs alu_*.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant  <= 1'b1;
         op_id       <= 1'b0;
         alu_a       <= 8'h00;
         alu_b       <= 8'h00;
         alu_op      <= 4'h0;
         rsp_id      <= 1'b0;
         rsp_result  <= 8'h00;
         rsp_product <= 16'h0000;
         rsp_of      <= 1'b0;
         rsp_zero    <= 1'b0;
         rsp_slt     <= 1'b0;
         rsp_err     <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= grant_id;
            op_id      <= grant_id;
            if (illegal) begin
               rsp_id      <= grant_id;
               rsp_result  <= 8'h00;
               rsp_product <= 16'h0000;
               rsp_of      <= 1'b0;
               rsp_zero    <= 1'b0;
               rsp_slt     <= 1'b0;
               rsp_err     <= 1'b1;
            end else begin
               alu_a  <= sel_a;
               alu_b  <= sel_b;
               alu_op <= sel_op;
            end
         end
         if (state == EXEC) begin
            rsp_id      <= op_id;
            rsp_result  <= alu_result;
            rsp_product <= alu_product;
            rsp_of      <= alu_of;
            rsp_zero    <= alu_zero;
            rsp_slt     <= alu_slt;
            rsp_err     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a small ALU model and a response scoreboard.
// Stimulus pushes expected responses on request handshake; a monitor pops on response handshake.
module tb_alu_req_scheduler;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [7:0]  alu_result;
   logic [15:0] alu_product;
   logic        alu_of, alu_zero, alu_slt;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [7:0]  rsp_result;
   logic [15:0] rsp_product;
   logic        rsp_of, rsp_zero, rsp_slt, rsp_err;
   logic        busy;

   typedef struct packed {
      logic        id;
      logic [7:0]  result;
      logic [15:0] product;
      logic        ovf;
      logic        zero;
      logic        slt;
      logic        err;
   } rsp_t;

   rsp_t        sb[$];
   rsp_t        exp_rsp;
   logic [28:0] rsp_all;
   int          vectors     = 0;
   int          miscompares = 0;

   localparam rsp_t ADD_EXP = rsp_t'{1'b0, 8'h08, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam rsp_t AND_EXP = rsp_t'{1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam rsp_t OR_EXP  = rsp_t'{1'b1, 8'hFC, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam rsp_t MUL_EXP = rsp_t'{1'b1, 8'h00, 16'hFFFA, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam rsp_t ILL_EXP = rsp_t'{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};

   assign rsp_all = {rsp_id, rsp_result, rsp_product, rsp_of, rsp_zero, rsp_slt, rsp_err};

   alu_req_scheduler dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_product(alu_product),
      .alu_of(alu_of), .alu_zero(alu_zero), .alu_slt(alu_slt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_product(rsp_product),
      .rsp_of(rsp_of), .rsp_zero(rsp_zero), .rsp_slt(rsp_slt),
      .rsp_err(rsp_err), .busy(busy)
   );

   // Reference ALU: 0001 AND, 0010 OR, 1001 ADD, 1011 signed MUL into product only.
   always_comb begin
      alu_result  = 8'h00;
      alu_product = 16'h0000;
      alu_of      = 1'b0;
      case (alu_op)
         4'b0001: alu_result = alu_a & alu_b;
         4'b0010: alu_result = alu_a | alu_b;
         4'b1001: begin
            alu_result = alu_a + alu_b;
            alu_of     = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
         end
         4'b1011: alu_product = 16'($signed(alu_a) * $signed(alu_b));
         default: ;
      endcase
      alu_zero = (alu_result == 8'h00);
      alu_slt  = ($signed(alu_a) < $signed(alu_b));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: got %0h expected none", rsp_all);
         end else begin
            exp_rsp = sb.pop_front();
            check("rsp", 32'(rsp_all), 32'(exp_rsp));
         end
      end
   end

   task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      if (id == 0) begin
         req0_a = a; req0_b = b; req0_op = op; req_valid[0] = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_op = op; req_valid[1] = 1'b1;
      end
   endtask

   // Waits (bounded) for a grant, then checks which requester got it.
   task automatic wait_grant(input logic [1:0] exp_ready);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (|req_ready) break;
      end
      check("grant", 32'(req_ready), 32'(exp_ready));
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      @(posedge clk); #1;
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b1; req_valid = 2'b00;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {req_ready, rsp_valid, busy}, 0);
      check("rst_alu", {alu_a, alu_b, alu_op}, 0);
      check("rst_rsp", 32'(rsp_all), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single add from requester 0
      set_req(0, 8'h05, 8'h03, 4'b1001);
      wait_grant(2'b01);
      sb.push_back(ADD_EXP);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("exec_rsp_valid", rsp_valid, 0);
      check("exec_alu", {alu_a, alu_b, alu_op}, {8'h05, 8'h03, 4'b1001});
      @(negedge clk);
      check("add_rsp_valid", rsp_valid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("add_idle", {busy, rsp_valid}, 0);

      // Multiply from requester 1 with back-pressure
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_req(1, 8'hFE, 8'h03, 4'b1011);
      wait_grant(2'b10);
      sb.push_back(MUL_EXP);
      @(posedge clk); #1;
      req_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      check("bp_rsp_valid", rsp_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_ctrl", {rsp_valid, busy, req_ready}, 4'b1100);
         check("bp_data", 32'(rsp_all), 32'(MUL_EXP));
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_idle", {busy, rsp_valid}, 0);

      // Round-robin with both requesters continuously valid
      @(posedge clk); #1;
      set_req(0, 8'hF0, 8'h3C, 4'b0001);
      set_req(1, 8'hF0, 8'h3C, 4'b0010);
      for (int k = 0; k < 4; k++) begin
         wait_grant((k % 2) != 0 ? 2'b10 : 2'b01);
         sb.push_back((k % 2) != 0 ? OR_EXP : AND_EXP);
         @(posedge clk); #1;
         if (k == 3) req_valid = 2'b00;
      end
      drain();

      // Illegal op: no EXEC cycle, alu_* keep the last legal operands
      set_req(0, 8'hAA, 8'h55, 4'b1110);
      wait_grant(2'b01);
      sb.push_back(ILL_EXP);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("ill_rsp_valid", rsp_valid, 1);
      check("ill_alu_hold", {alu_a, alu_b, alu_op}, {8'hF0, 8'h3C, 4'b0010});
      drain();

      // Reset during EXEC discards the operation
      set_req(0, 8'h01, 8'h02, 4'b1001);
      wait_grant(2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("rst_exec_alu", {alu_a, alu_b, alu_op}, {8'h01, 8'h02, 4'b1001});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_alu", {alu_a, alu_b, alu_op}, 0);
      check("post_rst_rsp", 32'(rsp_all), 0);
      for (int i = 0; i < 3; i++) begin
         check("post_rst_idle", {rsp_valid, busy, req_ready}, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      set_req(0, 8'hF0, 8'h3C, 4'b0001);
      set_req(1, 8'hF0, 8'h3C, 4'b0010);
      wait_grant(2'b01);
      sb.push_back(AND_EXP);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Sequencer and two-port arbiter that shares one combinational 8-bit ALU between two requesters. Each requester submits an operation (a, b, op) over a valid/ready handshake. The scheduler grants round-robin, registers the operands, and holds them on the ALU for one settle cycle. It then captures the ALU outputs and flags into a response register and returns the response, tagged with the requester id, over a second valid/ready handshake. It sits between the instruction-issue logic and the ALU instance; the ALU itself stays outside this block.

## Interface
Parameters:
- none (widths fixed by the ALU: 8-bit operands, 4-bit opcode, 16-bit product)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  2  request valid, bit i = requester i
- req_ready  output  2  request accepted this cycle when req_valid[i] & req_ready[i]
- req0_a, req0_b  input  8 each  requester 0 operands
- req0_op  input  4  requester 0 opcode
- req1_a, req1_b  input  8 each  requester 1 operands
- req1_op  input  4  requester 1 opcode
- alu_a, alu_b  output  8 each  operands driven to ALU
- alu_op  output  4  opcode driven to ALU
- alu_result  input  8  ALU result
- alu_product  input  16  ALU product
- alu_of, alu_zero, alu_slt  input  1 each  ALU flags
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the operation
- rsp_result  output  8  captured result
- rsp_product  output  16  captured product
- rsp_of, rsp_zero, rsp_slt  output  1 each  captured flags
- rsp_err  output  1  illegal opcode (op ≥ 4'b1100)
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant one requester and assert its req_ready combinationally in the same cycle.
  - On the handshake, latch a/b/op/id into the operand register.
  - Go to EXEC for legal op; go to RESP directly for illegal op.
- Illegal-op response: rsp_err=1; result, product and all flags 0.
- Arbitration:
  - Only one requester is valid: that requester is granted.
  - Both are valid: the requester not served last is granted.
  - last_grant updates on every accepted request; reset value 1, so requester 0 wins the first tie.
- EXEC (one cycle):
  - alu_a/alu_b/alu_op are driven from the operand register.
  - At the end of the cycle, capture alu_result, alu_product, alu_of, alu_zero and alu_slt into the response register.
  - Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* fields stay stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE.
- req_ready is 0 in EXEC and RESP.
- req_ready never asserts for a requester whose req_valid is 0.
- alu_a/alu_b/alu_op hold the last issued operands outside EXEC; they are 0 after reset.
- No arithmetic in this block: ALU values pass through unmodified, with no width change.
- Reset:
  - Any state goes to IDLE; an in-flight operation is discarded with no response.
  - rsp_valid=0, busy=0, req_ready=0.
  - All rsp_* fields, operand registers and alu_* outputs = 0; last_grant=1.

## Timing
- Request accepted at edge N:
  - EXEC during cycle N+1.
  - rsp_valid high from cycle N+2 (after edge N+1).
- Illegal op: rsp_valid high from cycle N+1.
- Best-case throughput, with rsp_ready tied high: one operation per 3 cycles (accept, EXEC, RESP).
- The next grant occurs in the IDLE cycle that follows the response handshake.
- Back-pressure: while rsp_ready=0, the block stalls in RESP indefinitely and accepts no requests.
- Requests deasserted before acceptance are dropped silently; no request state is stored before the handshake.

## Test plan
- Single add: requester 0 sends a=8'h05, b=8'h03, op=4'b1001 with rsp_ready=1.
  - Expect req_ready[0]=1 in the same cycle.
  - Expect rsp_valid 2 cycles later with rsp_id=0, rsp_result=8'h08, rsp_err=0.
- Round-robin: both requesters valid continuously; req0 op=4'b0001 (a=F0, b=3C), req1 op=4'b0010 (a=F0, b=3C).
  - Expect grants 0,1,0,1.
  - Expect results 8'h30, 8'hFC alternating, with matching rsp_id.
- Multiply: requester 1 sends a=8'hFE (−2), b=8'h03, op=4'b1011.
  - Expect rsp_product=16'hFFFA and rsp_result=0.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises.
  - Expect rsp_* stable, busy=1, req_ready=2'b00 throughout.
  - When rsp_ready rises, expect one handshake, then IDLE.
- Illegal op: requester 0 sends op=4'b1110.
  - Expect rsp_valid 1 cycle after acceptance, rsp_err=1, all data and flags 0, and no EXEC cycle (alu_op unchanged).
- Reset mid-operation: assert rst during EXEC.
  - Expect rsp_valid never asserted for that request.
  - After release, expect all outputs 0 and the next tie granted to requester 0.
